message_joiner: RTL and testbench

Downstream companion to `message_slicer`. It accepts a stream of `WIDTH`-bit slices, each marked by `in_nd`, and reassembles every `N_SLICES` consecutive slices into one `WIDTH*N_SLICES`-bit word, emitted with a one-cycle `out_nd` pulse. If a partially assembled word stalls for too long, it is discarded and the block pulses `error`, so the output stays word-aligned with the slicer's input.

---
 rtl/message_joiner_pkg.sv | 16 +
 rtl/message_joiner_if.sv | 31 +++
 rtl/message_joiner.sv | 98 +++++++++
 tb/tb_message_joiner.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/message_joiner_pkg.sv
// Shared message defaults and the slot-ordering helper used by the slicer/joiner pair.
// Slot 0 is the most-significant slice of a word; higher slot numbers move toward bit 0.
package message_joiner_pkg;

  localparam int DEF_N_SLICES     = 4;
  localparam int DEF_LOG_N_SLICES = 2;
  localparam int DEF_WIDTH        = 32;
  localparam int DEF_MAX_GAP      = 16;
  localparam int DEF_LOG_MAX_GAP  = 5;

  // Low bit position of a slot inside the assembled word (slot 0 = MS slot).
  function automatic int slot_lsb(input int slot, input int n_slices, input int width);
    return (n_slices - 1 - slot) * width;
  endfunction

endpackage

// File: rtl/message_joiner_if.sv
// Slice-in / word-out bundle between a message slicer source and the joiner.
interface message_joiner_if
  import message_joiner_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int N_SLICES = DEF_N_SLICES
) ();

  logic [WIDTH-1:0]          in_data;
  logic                      in_nd;
  logic [WIDTH*N_SLICES-1:0] out_data;
  logic                      out_nd;
  logic                      error;

  modport slave (
    input  in_data,
    input  in_nd,
    output out_data,
    output out_nd,
    output error
  );

  modport master (
    output in_data,
    output in_nd,
    input  out_data,
    input  out_nd,
    input  error
  );

endinterface

// File: rtl/message_joiner.sv
// Reassembles N_SLICES consecutive slices (MS slot first) into one word; a partial
// word idle for MAX_GAP consecutive cycles is dropped with a one-cycle error pulse.
module message_joiner
  import message_joiner_pkg::*;
#(
  parameter int N_SLICES     = DEF_N_SLICES,
  parameter int LOG_N_SLICES = DEF_LOG_N_SLICES,
  parameter int WIDTH        = DEF_WIDTH,
  parameter int MAX_GAP      = DEF_MAX_GAP,
  parameter int LOG_MAX_GAP  = DEF_LOG_MAX_GAP
) (
  input  logic             clk,
  input  logic             rst_n,
  message_joiner_if.slave  bus
);

  localparam int WORD_W = WIDTH * N_SLICES;

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_FILLING = 1'b1;

  localparam logic [LOG_N_SLICES-1:0] LAST_SLOT = LOG_N_SLICES'(N_SLICES - 1);
  localparam logic [LOG_MAX_GAP-1:0]  GAP_LAST  = LOG_MAX_GAP'(MAX_GAP - 1);

  logic [0:0]              state_q,    state_d;
  logic [LOG_N_SLICES-1:0] count_q,    count_d;
  logic [LOG_MAX_GAP-1:0]  gap_q,      gap_d;
  logic [WORD_W-1:0]       asm_q,      asm_d;
  logic [WORD_W-1:0]       out_data_q, out_data_d;
  logic                    out_nd_q,   out_nd_d;
  logic                    error_q,    error_d;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    gap_d      = gap_q;
    asm_d      = asm_q;
    out_data_d = out_data_q;
    out_nd_d   = 1'b0;
    error_d    = 1'b0;

    if (bus.in_nd) begin
      // A slice always wins over a pending timeout in the same cycle.
      for (int s = 0; s < N_SLICES; s++) begin
        if (count_q == LOG_N_SLICES'(s)) begin
          asm_d[slot_lsb(s, N_SLICES, WIDTH) +: WIDTH] = bus.in_data;
        end
      end
      gap_d = '0;
      if (count_q == LAST_SLOT) begin
        out_data_d = {asm_q[WORD_W-1:WIDTH], bus.in_data};
        out_nd_d   = 1'b1;
        count_d    = '0;
        state_d    = ST_IDLE;
      end else begin
        count_d = count_q + LOG_N_SLICES'(1);
        state_d = ST_FILLING;
      end
    end else if (state_q == ST_FILLING) begin
      if (gap_q == GAP_LAST) begin
        error_d = 1'b1;
        count_d = '0;
        gap_d   = '0;
        state_d = ST_IDLE;
      end else begin
        gap_d = gap_q + LOG_MAX_GAP'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      gap_q      <= '0;
      out_data_q <= '0;
      out_nd_q   <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      gap_q      <= gap_d;
      out_data_q <= out_data_d;
      out_nd_q   <= out_nd_d;
      error_q    <= error_d;
    end
  end

  // Every slot is rewritten before a word completes, so the assembly register needs no reset.
  always_ff @(posedge clk) begin
    asm_q <= asm_d;
  end

  assign bus.out_data = out_data_q;
  assign bus.out_nd   = out_nd_q;
  assign bus.error    = error_q;

endmodule

// File: tb/tb_message_joiner.sv
// Bench for message_joiner at WIDTH=8, N_SLICES=4, MAX_GAP=3: per-cycle vector table,
// hand-written reset sequence, and a queue scoreboard for streaming and slicer round trip.
module tb_message_joiner;

  localparam int W  = 8;
  localparam int NS = 4;
  localparam int MG = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  message_joiner_if #(.WIDTH(W), .N_SLICES(NS)) bus ();

  message_joiner #(
    .N_SLICES(NS), .LOG_N_SLICES(2), .WIDTH(W), .MAX_GAP(MG), .LOG_MAX_GAP(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic        nd;
    logic [7:0]  data;
    logic        exp_nd;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [31:0] sb_q[$];
  bit          sb_on      = 1'b0;
  bit          spacing_on = 1'b0;
  int          last_nd    = -1;
  int          rx_words   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic sb_check();
    logic [31:0] exp_w;
    if (bus.out_nd === 1'b1) begin
      rx_words++;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_word: got %h expected none (cycle %0d)", bus.out_data, cyc);
      end else begin
        exp_w = sb_q.pop_front();
        chk("sb_word", bus.out_data, exp_w);
      end
      if (spacing_on && last_nd >= 0) chk("nd_spacing", 32'(cyc - last_nd), 32'd4);
      last_nd = cyc;
    end
    if (bus.error !== 1'b0) chk("sb_error", {31'd0, bus.error}, 32'd0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (sb_on) sb_check();
  endtask

  task automatic drive(input logic nd, input logic [7:0] d);
    bus.in_nd   = nd;
    bus.in_data = d;
    step();
  endtask

  vec_t vecs[$];

  function automatic vec_t v(input logic nd, input logic [7:0] d, input logic end_nd,
                             input logic [31:0] ed, input logic ee);
    vec_t r;
    r.nd = nd; r.data = d; r.exp_nd = end_nd; r.exp_data = ed; r.exp_err = ee;
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] word;
    logic [7:0]  sl;
    int          gap;

    bus.in_nd   = 1'b0;
    bus.in_data = '0;
    rst_n       = 1'b0;
    repeat (3) step();
    chk("reset_out_data", bus.out_data, 32'h0);
    chk("reset_out_nd",   {31'd0, bus.out_nd}, 32'd0);
    chk("reset_error",    {31'd0, bus.error}, 32'd0);
    rst_n = 1'b1;

    // back-to-back
    vecs.push_back(v(1, 8'h11, 0, 32'h0, 0));
    vecs.push_back(v(1, 8'h22, 0, 32'h0, 0));
    vecs.push_back(v(1, 8'h33, 0, 32'h0, 0));
    vecs.push_back(v(1, 8'h44, 1, 32'h11223344, 0));
    vecs.push_back(v(0, 8'h00, 0, 32'h11223344, 0));
    // timeout, then a clean word
    vecs.push_back(v(1, 8'hAA, 0, 32'h11223344, 0));
    vecs.push_back(v(1, 8'hBB, 0, 32'h11223344, 0));
    vecs.push_back(v(0, 8'h00, 0, 32'h11223344, 0));
    vecs.push_back(v(0, 8'h00, 0, 32'h11223344, 0));
    vecs.push_back(v(0, 8'h00, 0, 32'h11223344, 1));
    vecs.push_back(v(0, 8'h00, 0, 32'h11223344, 0));
    vecs.push_back(v(0, 8'h00, 0, 32'h11223344, 0));
    vecs.push_back(v(1, 8'h01, 0, 32'h11223344, 0));
    vecs.push_back(v(1, 8'h02, 0, 32'h11223344, 0));
    vecs.push_back(v(1, 8'h03, 0, 32'h11223344, 0));
    vecs.push_back(v(1, 8'h04, 1, 32'h01020304, 0));
    // tie-break: slice arrives on the cycle the gap would expire
    vecs.push_back(v(1, 8'hAA, 0, 32'h01020304, 0));
    vecs.push_back(v(0, 8'h00, 0, 32'h01020304, 0));
    vecs.push_back(v(0, 8'h00, 0, 32'h01020304, 0));
    vecs.push_back(v(1, 8'hBB, 0, 32'h01020304, 0));
    vecs.push_back(v(1, 8'hCC, 0, 32'h01020304, 0));
    vecs.push_back(v(1, 8'hDD, 1, 32'hAABBCCDD, 0));
    // idle in IDLE never times out
    vecs.push_back(v(0, 8'h00, 0, 32'hAABBCCDD, 0));
    vecs.push_back(v(0, 8'h00, 0, 32'hAABBCCDD, 0));
    vecs.push_back(v(0, 8'h00, 0, 32'hAABBCCDD, 0));
    vecs.push_back(v(0, 8'h00, 0, 32'hAABBCCDD, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].nd, vecs[i].data);
      chk($sformatf("vec%0d_out_nd", i),   {31'd0, bus.out_nd}, {31'd0, vecs[i].exp_nd});
      chk($sformatf("vec%0d_error", i),    {31'd0, bus.error},  {31'd0, vecs[i].exp_err});
      chk($sformatf("vec%0d_out_data", i), bus.out_data, vecs[i].exp_data);
    end

    // reset mid-word
    drive(1, 8'h55);
    drive(1, 8'h66);
    bus.in_nd = 1'b0;
    rst_n     = 1'b0;
    step();
    chk("rstmid_out_data", bus.out_data, 32'h0);
    chk("rstmid_out_nd",   {31'd0, bus.out_nd}, 32'd0);
    chk("rstmid_error",    {31'd0, bus.error}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < MG + 1; i++) begin
      drive(0, 8'h00);
      chk("rstmid_no_error", {31'd0, bus.error}, 32'd0);
    end
    drive(1, 8'h01);
    drive(1, 8'h02);
    drive(1, 8'h03);
    chk("rstmid_hold", bus.out_data, 32'h0);
    drive(1, 8'h04);
    chk("rstmid_word_nd", {31'd0, bus.out_nd}, 32'd1);
    chk("rstmid_word",    bus.out_data, 32'h01020304);
    drive(0, 8'h00);

    // continuous stream through the scoreboard
    sb_on      = 1'b1;
    spacing_on = 1'b1;
    last_nd    = -1;
    rx_words   = 0;
    for (int i = 1; i <= 12; i++) begin
      if (i % 4 == 0) sb_q.push_back({8'(i - 3), 8'(i - 2), 8'(i - 1), 8'(i)});
      drive(1, 8'(i));
    end
    drive(0, 8'h00);
    chk("stream_words", 32'(rx_words), 32'd3);
    spacing_on = 1'b0;

    // slicer round trip with random intra-word gaps below the timeout
    rx_words = 0;
    for (int w = 0; w < 20; w++) begin
      word = $urandom;
      sb_q.push_back(word);
      for (int s = 0; s < NS; s++) begin
        gap = $urandom_range(0, MG - 1);
        for (int g = 0; g < gap; g++) drive(0, 8'h00);
        sl = word[(NS - 1 - s) * W +: W];
        drive(1, sl);
      end
    end
    repeat (4) drive(0, 8'h00);
    chk("roundtrip_words", 32'(rx_words), 32'd20);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    sb_on = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
